ysyx_23060061_sram_responder: RTL and testbench

AXI4 responder (slave) modelling the on-chip SRAM behind the crossbar's SRAM port. It accepts read and write bursts, stores data in an internal word array, and returns data and responses after a configurable latency. It is the counterpart of the crossbar's `sram_*` initiator-side bundle: each port here connects 1:1 to the same-named `sram_*` crossbar port. The read and write paths run independently of each other.

---
 rtl/ysyx_23060061_sram_responder.sv | 207 ++++++++++++++++++++
 tb/tb_ysyx_23060061_sram_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060061_sram_responder.sv
`default_nettype none
// ============================================================================
// Module : ysyx_23060061_sram_responder
// Brief  : AXI4 SRAM responder; word array behind independent read/write
//          burst FSMs with configurable response latency.
// Rev    : 1.0  initial release
// ============================================================================
module ysyx_23060061_sram_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned WR_LAT     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic [3:0]  rid,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  output logic        bvalid,
  input  logic        bready
);
  localparam int unsigned c_DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [1:0]  c_OKAY   = 2'b00;
  localparam logic [1:0]  c_SLVERR = 2'b10;
  localparam logic [1:0]  c_INCR   = 2'b01;
  localparam logic [15:0] c_RD_LAT = 16'(RD_LAT);
  localparam logic [15:0] c_WR_LAT = 16'(WR_LAT);

  typedef logic [DEPTH_LOG2-1:0] idx_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_WAIT = 2'd2, W_RESP = 2'd3} wr_state_t;

  logic [31:0] r_mem [c_DEPTH];

  rd_state_t   r_rstate;
  idx_t        r_ridx;
  logic [3:0]  r_rid;
  logic [7:0]  r_rlen;
  logic [1:0]  r_rburst;
  logic [7:0]  r_rbeat;
  logic [15:0] r_rcnt;
  logic        r_rerr;
  logic [31:0] r_rdata;

  wr_state_t   r_wstate;
  idx_t        r_widx;
  logic [3:0]  r_wid;
  logic [7:0]  r_wlen;
  logic [1:0]  r_wburst;
  logic [7:0]  r_wbeat;
  logic [15:0] r_wcnt;
  logic        r_wcfg_err;
  logic        r_werr;

  idx_t w_ar_idx;
  idx_t w_aw_idx;
  idx_t w_rnext_idx;
  idx_t w_wnext_idx;
  logic w_ar_err;
  logic w_aw_err;
  logic w_w_hs;
  logic w_wbeat_bad;
  logic w_unused;

  assign w_ar_idx    = araddr[DEPTH_LOG2+1:2];
  assign w_aw_idx    = awaddr[DEPTH_LOG2+1:2];
  assign w_ar_err    = arburst[1] | (arsize > 3'd2);
  assign w_aw_err    = awburst[1] | (awsize > 3'd2);
  assign w_rnext_idx = (r_rburst == c_INCR) ? r_ridx + idx_t'(1) : r_ridx;
  assign w_wnext_idx = (r_wburst == c_INCR) ? r_widx + idx_t'(1) : r_widx;
  assign w_w_hs      = wvalid && (r_wstate == W_DATA);
  // A beat is bad if the burst is unsupported or wlast disagrees with the beat count.
  assign w_wbeat_bad = r_wcfg_err || (wlast != (r_wbeat == r_wlen));
  assign w_unused    = ^{araddr[31:DEPTH_LOG2+2], araddr[1:0], awaddr[31:DEPTH_LOG2+2], awaddr[1:0]};

  assign arready = (r_rstate == R_IDLE);
  assign rvalid  = (r_rstate == R_DATA);
  assign rlast   = (r_rstate == R_DATA) && (r_rbeat == r_rlen);
  assign rdata   = r_rdata;
  assign rid     = r_rid;
  assign rresp   = r_rerr ? c_SLVERR : c_OKAY;

  assign awready = (r_wstate == W_IDLE);
  assign wready  = (r_wstate == W_DATA);
  assign bvalid  = (r_wstate == W_RESP);
  assign bid     = r_wid;
  assign bresp   = r_werr ? c_SLVERR : c_OKAY;

  always_ff @(posedge clk) begin
    if (w_w_hs && !w_wbeat_bad) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) r_mem[r_widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read data is captured one cycle ahead of the beat so it stays stable while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate <= R_IDLE;
      r_ridx   <= '0;
      r_rid    <= '0;
      r_rlen   <= '0;
      r_rburst <= '0;
      r_rbeat  <= '0;
      r_rcnt   <= '0;
      r_rerr   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (arvalid) begin
          r_ridx   <= w_ar_idx;
          r_rid    <= arid;
          r_rlen   <= arlen;
          r_rburst <= arburst;
          r_rbeat  <= '0;
          r_rerr   <= w_ar_err;
          r_rcnt   <= c_RD_LAT;
          r_rdata  <= w_ar_err ? 32'd0 : r_mem[w_ar_idx];
          r_rstate <= (RD_LAT == 0) ? R_DATA : R_WAIT;
        end
        R_WAIT: begin
          r_rcnt  <= r_rcnt - 16'd1;
          r_rdata <= r_rerr ? 32'd0 : r_mem[r_ridx];
          if (r_rcnt == 16'd1) r_rstate <= R_DATA;
        end
        R_DATA: if (rready) begin
          if (r_rbeat == r_rlen) begin
            r_rstate <= R_IDLE;
          end else begin
            r_rbeat <= r_rbeat + 8'd1;
            r_ridx  <= w_rnext_idx;
            r_rdata <= r_rerr ? 32'd0 : r_mem[w_rnext_idx];
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate   <= W_IDLE;
      r_widx     <= '0;
      r_wid      <= '0;
      r_wlen     <= '0;
      r_wburst   <= '0;
      r_wbeat    <= '0;
      r_wcnt     <= '0;
      r_wcfg_err <= 1'b0;
      r_werr     <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: if (awvalid) begin
          r_widx     <= w_aw_idx;
          r_wid      <= awid;
          r_wlen     <= awlen;
          r_wburst   <= awburst;
          r_wbeat    <= '0;
          r_wcfg_err <= w_aw_err;
          r_werr     <= 1'b0;
          r_wstate   <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          r_werr  <= r_werr | w_wbeat_bad;
          r_wbeat <= r_wbeat + 8'd1;
          r_widx  <= w_wnext_idx;
          if (wlast) begin
            r_wcnt   <= c_WR_LAT;
            r_wstate <= (WR_LAT == 0) ? W_RESP : W_WAIT;
          end
        end
        W_WAIT: begin
          r_wcnt <= r_wcnt - 16'd1;
          if (r_wcnt == 16'd1) r_wstate <= W_RESP;
        end
        W_RESP: if (bready) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060061_sram_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_ysyx_23060061_sram_responder
// Brief  : Directed self-checking bench for the AXI4 SRAM responder.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ysyx_23060061_sram_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] araddr;  logic [3:0] arid;  logic [7:0] arlen;  logic [2:0] arsize;  logic [1:0] arburst;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [31:0] rdata;   logic [1:0] rresp; logic [3:0] rid;
  logic [31:0] awaddr;  logic [3:0] awid;  logic [7:0] awlen;  logic [2:0] awsize;  logic [1:0] awburst;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [31:0] wdata;   logic [3:0] wstrb; logic [1:0] bresp;  logic [3:0] bid;

  logic [31:0] z_araddr; logic [3:0] z_arid; logic [7:0] z_arlen; logic [2:0] z_arsize; logic [1:0] z_arburst;
  logic z_arvalid, z_arready, z_rlast, z_rvalid, z_rready;
  logic [31:0] z_rdata;  logic [1:0] z_rresp; logic [3:0] z_rid;
  logic [31:0] z_awaddr; logic [3:0] z_awid; logic [7:0] z_awlen; logic [2:0] z_awsize; logic [1:0] z_awburst;
  logic z_awvalid, z_awready, z_wlast, z_wvalid, z_wready, z_bvalid, z_bready;
  logic [31:0] z_wdata;  logic [3:0] z_wstrb; logic [1:0] z_bresp; logic [3:0] z_bid;

  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] rb_data [16];
  logic [1:0]  rb_resp [16];
  logic        rb_last [16];
  logic [3:0]  rb_id   [16];
  int          rb_cyc  [16];
  int          stall_chg;

  ysyx_23060061_sram_responder u_dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready)
  );

  ysyx_23060061_sram_responder #(.DEPTH_LOG2(10), .RD_LAT(0), .WR_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .araddr(z_araddr), .arid(z_arid), .arlen(z_arlen), .arsize(z_arsize), .arburst(z_arburst),
    .arvalid(z_arvalid), .arready(z_arready),
    .rdata(z_rdata), .rresp(z_rresp), .rid(z_rid), .rlast(z_rlast), .rvalid(z_rvalid), .rready(z_rready),
    .awaddr(z_awaddr), .awid(z_awid), .awlen(z_awlen), .awsize(z_awsize), .awburst(z_awburst),
    .awvalid(z_awvalid), .awready(z_awready),
    .wdata(z_wdata), .wstrb(z_wstrb), .wlast(z_wlast), .wvalid(z_wvalid), .wready(z_wready),
    .bresp(z_bresp), .bid(z_bid), .bvalid(z_bvalid), .bready(z_bready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write burst: nbeats beats from wbuf/sbuf, wlast on beat last_at; lat counts cycles from last W to bvalid.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input int nbeats, input int last_at,
                          output logic [1:0] resp, output logic [3:0] bid_o, output int lat);
    bit ok;
    int n_hs;
    resp = 2'bxx; bid_o = 4'bxxxx; lat = -1; n_hs = 0;
    awaddr = addr; awid = id; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = awready; @(posedge clk); #1; end
    awvalid = 1'b0;
    if (!ok) begin checks++; errors++; $display("FAIL aw_timeout: awready never seen"); return; end
    for (int b = 0; b < nbeats; b++) begin
      wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == last_at); wvalid = 1'b1;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = wready; n_hs = cyc; @(posedge clk); #1; end
      if (!ok) begin checks++; errors++; $display("FAIL w_timeout: wready never seen on beat %0d", b); end
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1; lat = cyc - n_hs; resp = bresp; bid_o = bid; end
      @(posedge clk); #1;
    end
    bready = 1'b0;
    if (!ok) begin checks++; errors++; $display("FAIL b_timeout: bvalid never seen"); end
  endtask

  // Read burst: rready follows rpat bit p on the p-th cycle that rvalid is high.
  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [15:0] rpat,
                         output int nb, output int lat);
    bit ok, held, done;
    int n_ar, p;
    logic [31:0] hd; logic [1:0] hr; logic hl; logic [3:0] hi;
    araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    ok = 0; n_ar = 0; nb = 0; lat = -1; p = 0; held = 0; done = 0; stall_chg = 0;
    hd = '0; hr = '0; hl = 1'b0; hi = '0;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = arready; n_ar = cyc; @(posedge clk); #1; end
    arvalid = 1'b0;
    if (!ok) begin checks++; errors++; $display("FAIL ar_timeout: arready never seen"); return; end
    for (int c = 0; c < 200 && !done; c++) begin
      rready = rpat[p % 16];
      @(negedge clk);
      if (rvalid) begin
        if (lat < 0) lat = cyc - n_ar;
        if (held && (rdata !== hd || rresp !== hr || rlast !== hl || rid !== hi)) stall_chg++;
        if (rready) begin
          rb_data[nb] = rdata; rb_resp[nb] = rresp; rb_last[nb] = rlast; rb_id[nb] = rid; rb_cyc[nb] = cyc;
          nb++; held = 0;
          if (rlast || nb == 16) done = 1;
        end else begin
          held = 1; hd = rdata; hr = rresp; hl = rlast; hi = rid;
        end
        p++;
      end
      @(posedge clk); #1;
    end
    rready = 1'b0;
    if (!done) begin checks++; errors++; $display("FAIL r_timeout: burst incomplete after %0d beats", nb); end
  endtask

  task automatic test_reset();
    checks++; if ({arready, awready} !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b expected 11", {arready, awready}); end
    checks++; if ({rvalid, rlast, wready, bvalid} !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", {rvalid, rlast, wready, bvalid}); end
    checks++; if ({rdata, rresp, rid, bresp, bid} !== 44'd0) begin errors++; $display("FAIL reset_payload: got %h expected 0", {rdata, rresp, rid, bresp, bid}); end
  endtask

  task automatic test_single();
    logic [1:0] r; logic [3:0] b; int lat, nb;
    wbuf[0] = 32'h12345678; sbuf[0] = 4'hF;
    do_write(32'h8000_0010, 4'h5, 8'd0, 2'b01, 1, 0, r, b, lat);
    checks++; if (r !== 2'b00 || b !== 4'h5) begin errors++; $display("FAIL single_bresp: got resp %b id %h expected 00 5", r, b); end
    checks++; if (lat != 2) begin errors++; $display("FAIL single_blat: got %0d expected 2", lat); end
    do_read(32'h8000_0010, 4'h9, 8'd0, 3'd2, 2'b01, 16'hFFFF, nb, lat);
    checks++; if (nb != 1 || rb_data[0] !== 32'h12345678 || rb_last[0] !== 1'b1 || rb_id[0] !== 4'h9 || rb_resp[0] !== 2'b00)
      begin errors++; $display("FAIL single_read: got n=%0d %h last %b id %h resp %b expected 1 12345678 1 9 00", nb, rb_data[0], rb_last[0], rb_id[0], rb_resp[0]); end
    checks++; if (lat != 2) begin errors++; $display("FAIL single_rlat: got %0d expected 2", lat); end
  endtask

  task automatic test_byte_strobe();
    logic [1:0] r; logic [3:0] b; int lat, nb;
    wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF; do_write(32'h40, 4'h1, 8'd0, 2'b01, 1, 0, r, b, lat);
    wbuf[0] = 32'h000000AA; sbuf[0] = 4'b0001; do_write(32'h40, 4'h1, 8'd0, 2'b01, 1, 0, r, b, lat);
    do_read(32'h40, 4'h2, 8'd0, 3'd2, 2'b01, 16'hFFFF, nb, lat);
    checks++; if (rb_data[0] !== 32'hFFFFFFAA) begin errors++; $display("FAIL strobe_lane0: got %h expected FFFFFFAA", rb_data[0]); end
    wbuf[0] = 32'h00550000; sbuf[0] = 4'b0100; do_write(32'h40, 4'h1, 8'd0, 2'b01, 1, 0, r, b, lat);
    do_read(32'h40, 4'h2, 8'd0, 3'd0, 2'b01, 16'hFFFF, nb, lat);
    checks++; if (rb_data[0] !== 32'hFF55FFAA) begin errors++; $display("FAIL strobe_lane2: got %h expected FF55FFAA", rb_data[0]); end
  endtask

  task automatic test_incr_burst();
    logic [1:0] r; logic [3:0] b; int lat, nb;
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
    do_write(32'h20, 4'hA, 8'd3, 2'b01, 4, 3, r, b, lat);
    checks++; if (r !== 2'b00 || b !== 4'hA) begin errors++; $display("FAIL burst_bresp: got %b %h expected 00 A", r, b); end
    do_read(32'h20, 4'hC, 8'd3, 3'd2, 2'b01, 16'h002D, nb, lat);
    checks++; if (nb != 4) begin errors++; $display("FAIL incr_count: got %0d expected 4", nb); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rb_data[i] !== 32'(i + 1) || rb_last[i] !== (i == 3))
        begin errors++; $display("FAIL incr_beat%0d: got %h last %b expected %h last %b", i, rb_data[i], rb_last[i], i + 1, i == 3); end
    end
    checks++; if (stall_chg != 0) begin errors++; $display("FAIL incr_stall_stable: got %0d changes expected 0", stall_chg); end
    do_read(32'h20, 4'hC, 8'd3, 3'd2, 2'b01, 16'hFFFF, nb, lat);
    checks++; if (nb != 4 || rb_cyc[3] - rb_cyc[0] != 3) begin errors++; $display("FAIL incr_b2b: got span %0d expected 3", rb_cyc[3] - rb_cyc[0]); end
    do_read(32'h24, 4'hD, 8'd2, 3'd2, 2'b00, 16'hFFFF, nb, lat);
    checks++; if (nb != 3 || rb_data[0] !== 32'd2 || rb_data[2] !== 32'd2 || rb_last[2] !== 1'b1)
      begin errors++; $display("FAIL fixed_read: got n=%0d %h %h expected 3 2 2", nb, rb_data[0], rb_data[2]); end
  endtask

  task automatic test_errors();
    logic [1:0] r; logic [3:0] b; int lat, nb;
    do_read(32'h20, 4'h4, 8'd1, 3'd2, 2'b10, 16'hFFFF, nb, lat);
    checks++; if (nb != 2 || rb_resp[0] !== 2'b10 || rb_resp[1] !== 2'b10 || rb_data[0] !== 32'd0 || rb_data[1] !== 32'd0 || rb_last[1] !== 1'b1)
      begin errors++; $display("FAIL err_wrap_read: got n=%0d resp %b %b data %h %h expected 2 10 10 0 0", nb, rb_resp[0], rb_resp[1], rb_data[0], rb_data[1]); end
    do_read(32'h20, 4'h4, 8'd0, 3'd3, 2'b01, 16'hFFFF, nb, lat);
    checks++; if (rb_resp[0] !== 2'b10 || rb_data[0] !== 32'd0) begin errors++; $display("FAIL err_size_read: got %b %h expected 10 0", rb_resp[0], rb_data[0]); end
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    do_write(32'h10, 4'h7, 8'd1, 2'b01, 1, 0, r, b, lat);
    checks++; if (r !== 2'b10 || b !== 4'h7) begin errors++; $display("FAIL err_wlast: got %b %h expected 10 7", r, b); end
    do_read(32'h10, 4'h4, 8'd0, 3'd2, 2'b01, 16'hFFFF, nb, lat);
    checks++; if (rb_data[0] !== 32'h12345678) begin errors++; $display("FAIL err_no_write: got %h expected 12345678", rb_data[0]); end
  endtask

  task automatic test_no_early_w();
    wdata = 32'hBAD0BAD0; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (wready !== 1'b0) begin errors++; $display("FAIL early_w: got wready %b expected 0", wready); end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic test_index_wrap();
    logic [1:0] r; logic [3:0] b; int lat, nb;
    wbuf[0] = 32'hCAFEBABE; sbuf[0] = 4'hF;
    do_write(32'h0000_1030, 4'h2, 8'd0, 2'b01, 1, 0, r, b, lat);
    do_read(32'h30, 4'h2, 8'd0, 3'd2, 2'b01, 16'hFFFF, nb, lat);
    checks++; if (rb_data[0] !== 32'hCAFEBABE) begin errors++; $display("FAIL index_wrap: got %h expected CAFEBABE", rb_data[0]); end
  endtask

  task automatic test_reset_mid_burst();
    int seen, nb, lat; bit hit;
    araddr = 32'h20; arid = 4'h3; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1; rready = 1'b1;
    @(posedge clk); #1; arvalid = 1'b0;
    seen = 0; hit = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rvalid) seen++;
      if (seen == 2) begin hit = 1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!hit || rdata !== 32'd2) begin errors++; $display("FAIL rstmid_beat2: got hit %b data %h expected 1 2", hit, rdata); end
    rst = 1'b0; #1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid: got %b expected 0", rvalid); end
    @(posedge clk); @(negedge clk); rst = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    checks++; if (arready !== 1'b1 || rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got arready %b rvalid %b expected 1 0", arready, rvalid); end
    do_read(32'h28, 4'h6, 8'd0, 3'd2, 2'b01, 16'hFFFF, nb, lat);
    checks++; if (nb != 1 || rb_data[0] !== 32'd3 || rb_id[0] !== 4'h6) begin errors++; $display("FAIL rstmid_reread: got %h id %h expected 3 6", rb_data[0], rb_id[0]); end
  endtask

  task automatic test_concurrent();
    z_awaddr = 32'h50; z_awid = 4'h1; z_awlen = 8'd0; z_awsize = 3'd2; z_awburst = 2'b01; z_awvalid = 1'b1;
    @(posedge clk); #1; z_awvalid = 1'b0;
    z_wdata = 32'h11111111; z_wstrb = 4'hF; z_wlast = 1'b1; z_wvalid = 1'b1;
    @(posedge clk); #1; z_wvalid = 1'b0; z_wlast = 1'b0;
    @(negedge clk);
    checks++; if (z_bvalid !== 1'b1) begin errors++; $display("FAIL lat0_bvalid: got %b expected 1", z_bvalid); end
    z_bready = 1'b1; @(posedge clk); #1; z_bready = 1'b0;
    z_awvalid = 1'b1; @(posedge clk); #1; z_awvalid = 1'b0;
    z_wdata = 32'h22222222; z_wlast = 1'b1; z_wvalid = 1'b1;
    z_araddr = 32'h50; z_arid = 4'h7; z_arlen = 8'd0; z_arsize = 3'd2; z_arburst = 2'b01; z_arvalid = 1'b1; z_rready = 1'b1;
    @(negedge clk);
    checks++; if ({z_wready, z_arready} !== 2'b11) begin errors++; $display("FAIL conc_both_ready: got %b expected 11", {z_wready, z_arready}); end
    @(posedge clk); #1; z_wvalid = 1'b0; z_wlast = 1'b0; z_arvalid = 1'b0;
    @(negedge clk);
    checks++; if (z_rvalid !== 1'b1 || z_rdata !== 32'h11111111 || z_rid !== 4'h7 || z_rlast !== 1'b1)
      begin errors++; $display("FAIL conc_old: got v %b %h id %h expected 1 11111111 7", z_rvalid, z_rdata, z_rid); end
    z_bready = 1'b1;
    @(posedge clk); #1; z_rready = 1'b0; z_bready = 1'b0;
    z_arvalid = 1'b1; z_rready = 1'b1;
    @(posedge clk); #1; z_arvalid = 1'b0;
    @(negedge clk);
    checks++; if (z_rvalid !== 1'b1 || z_rdata !== 32'h22222222) begin errors++; $display("FAIL conc_new: got v %b %h expected 1 22222222", z_rvalid, z_rdata); end
    @(posedge clk); #1; z_rready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    z_araddr = '0; z_arid = '0; z_arlen = '0; z_arsize = '0; z_arburst = '0; z_arvalid = 1'b0; z_rready = 1'b0;
    z_awaddr = '0; z_awid = '0; z_awlen = '0; z_awsize = '0; z_awburst = '0; z_awvalid = 1'b0;
    z_wdata = '0; z_wstrb = '0; z_wlast = 1'b0; z_wvalid = 1'b0; z_bready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_byte_strobe();
    test_incr_burst();
    test_errors();
    test_no_early_w();
    test_index_wrap();
    test_reset_mid_burst();
    test_concurrent();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
